// File: rtl/tt_um_hu8785_countdown_timer_pkg.sv
// Shared types and constants for the countdown timer tile: FSM state encoding,
// counter widths and the TinyTapeout pin map.
package tt_um_hu8785_countdown_timer_pkg;

  localparam int CNT_W = 6;
  localparam int DIV_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int UI_START   = 0;
  localparam int UI_PAUSE   = 1;
  localparam int UI_RELOAD  = 2;
  localparam int UI_ABORT   = 3;
  localparam int UI_DIV_LSB = 4;

  localparam logic [7:0] UIO_OE_VAL = 8'hC0;

  // IDLE and DONE both accept a new start; RUN and PAUSED ignore it.
  function automatic logic accepts_start(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/tt_um_hu8785_countdown_timer_if.sv
// Control/handshake bundle between the timer FSM (master) and its prescaler (slave).
interface tt_um_hu8785_countdown_timer_if;
  import tt_um_hu8785_countdown_timer_pkg::*;

  logic             run;
  logic             clear;
  logic [DIV_W-1:0] div_sel;
  logic             tick;

  modport master (output run, output clear, output div_sel, input tick);
  modport slave  (input run, input clear, input div_sel, output tick);

endinterface

// File: rtl/tt_um_hu8785_countdown_timer_prescaler.sv
// Prescaler: counts while run is high and raises tick when the count reaches div_sel,
// giving a tick every div_sel+1 running clocks.
module tt_um_hu8785_countdown_timer_prescaler
  import tt_um_hu8785_countdown_timer_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  tt_um_hu8785_countdown_timer_if.slave     bus
);

  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_d;
  logic             tick;

  // '>=' rather than '==' so a live drop of div_sel below the count still ticks at once.
  always_comb begin
    tick    = bus.run && (presc_q >= bus.div_sel);
    presc_d = presc_q;
    if (bus.clear) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else if (bus.run) begin
      presc_d = presc_q + 1'b1;
    end
  end

  assign bus.tick = tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/tt_um_hu8785_countdown_timer.sv
// Loadable 6-bit countdown timer with prescaler, pause, abort and auto-reload.
// TinyTapeout top: every output comes straight from a register.
module tt_um_hu8785_countdown_timer
  import tt_um_hu8785_countdown_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  logic             start_i;
  logic             pause_i;
  logic             reload_i;
  logic             abort_i;
  logic [DIV_W-1:0] div_sel_i;
  logic [CNT_W-1:0] load_i;

  assign start_i   = ui_in[UI_START];
  assign pause_i   = ui_in[UI_PAUSE];
  assign reload_i  = ui_in[UI_RELOAD];
  assign abort_i   = ui_in[UI_ABORT];
  assign div_sel_i = ui_in[UI_DIV_LSB +: DIV_W];
  assign load_i    = uio_in[CNT_W-1:0];

  logic unused_pins;
  assign unused_pins = &{1'b0, ena, uio_in[7:CNT_W]};

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic             start_q;
  logic             tick_q;
  logic             zero_q;
  logic             done_q;
  logic             busy_q;
  logic             start_edge;

  assign start_edge = start_i & ~start_q;

  tt_um_hu8785_countdown_timer_if presc_bus ();

  // Pause and abort outrank the tick, so the prescaler simply does not run that cycle.
  assign presc_bus.run     = (state_q == ST_RUN) & ~abort_i & ~pause_i;
  assign presc_bus.clear   = abort_i | (start_edge & accepts_start(state_q));
  assign presc_bus.div_sel = div_sel_i;

  tt_um_hu8785_countdown_timer_prescaler u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (presc_bus.slave)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      start_q <= 1'b0;
      tick_q  <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= start_i;
      tick_q  <= 1'b0;
      zero_q  <= 1'b0;
      if (abort_i) begin
        state_q <= ST_IDLE;
        count_q <= '0;
        done_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start_edge) begin
              count_q <= load_i;
              if (load_i != '0) begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
              end else begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                zero_q  <= 1'b1;
                done_q  <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (pause_i) begin
              state_q <= ST_PAUSED;
            end else if (presc_bus.tick) begin
              tick_q <= 1'b1;
              if (count_q > CNT_W'(1)) begin
                count_q <= count_q - 1'b1;
              end else begin
                zero_q <= 1'b1;
                if (reload_i && (load_i != '0)) begin
                  count_q <= load_i;
                end else begin
                  count_q <= '0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
                end
              end
            end
          end
          ST_PAUSED: begin
            if (!pause_i) begin
              state_q <= ST_RUN;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign uo_out  = {zero_q, tick_q, count_q};
  assign uio_out = {done_q, busy_q, 6'b000000};
  assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_hu8785_countdown_timer.sv
// Bench for the countdown timer: directed scenarios plus randomized traffic against
// a cycle-level behavioural model, and a standalone prescaler period check.
module tb_tt_um_hu8785_countdown_timer;
  import tt_um_hu8785_countdown_timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic       ena = 1'b1;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_hu8785_countdown_timer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena)
  );

  tt_um_hu8785_countdown_timer_if pbus ();
  tt_um_hu8785_countdown_timer_prescaler u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pbus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 paused, 3 done.
  int m_mode, m_count, m_presc;
  bit m_tick, m_zero, m_done, m_start_prev;

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_presc = 0;
    m_tick = 0; m_zero = 0; m_done = 0; m_start_prev = 0;
  endtask

  task automatic model_step();
    bit start, pause, reload, abort, edge_seen;
    int div, load;
    start  = ui_in[0];
    pause  = ui_in[1];
    reload = ui_in[2];
    abort  = ui_in[3];
    div    = int'(ui_in[7:4]);
    load   = int'(uio_in[5:0]);
    edge_seen = start && !m_start_prev;
    m_start_prev = start;
    m_tick = 0;
    m_zero = 0;
    if (abort) begin
      m_mode = 0; m_count = 0; m_presc = 0; m_done = 0;
    end else if ((m_mode == 0 || m_mode == 3) && edge_seen) begin
      m_count = load; m_presc = 0; m_done = 0;
      if (load == 0) begin
        m_mode = 3; m_zero = 1; m_done = 1;
      end else begin
        m_mode = 1;
      end
    end else if (m_mode == 1 && pause) begin
      m_mode = 2;
    end else if (m_mode == 2) begin
      if (!pause) m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_presc >= div) begin
        m_presc = 0;
        m_tick = 1;
        if (m_count > 1) begin
          m_count = m_count - 1;
        end else begin
          m_zero = 1;
          if (reload && load != 0) begin
            m_count = load;
          end else begin
            m_count = 0; m_done = 1; m_mode = 3;
          end
        end
      end else begin
        m_presc = m_presc + 1;
      end
    end
  endtask

  task automatic cycle();
    logic [7:0] exp_uo, exp_uio;
    bit busy;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    busy    = (m_mode == 1) || (m_mode == 2);
    exp_uo  = {m_zero, m_tick, 6'(m_count)};
    exp_uio = {m_done, busy, 6'b000000};
    check_eq("uo_out", 32'(uo_out), 32'(exp_uo));
    check_eq("uio_out", 32'(uio_out), 32'(exp_uio));
    check_eq("uio_oe", 32'(uio_oe), 32'h0000_00C0);
  endtask

  task automatic go_idle();
    ui_in = 8'h08;
    cycle();
    ui_in = 8'h00;
    cycle();
  endtask

  task automatic presc_period(input int d);
    int last, ticks;
    last = -1;
    ticks = 0;
    pbus.div_sel = 4'(d);
    pbus.clear = 1'b1;
    pbus.run = 1'b0;
    @(posedge clk); #1;
    pbus.clear = 1'b0;
    pbus.run = 1'b1;
    for (int i = 0; i < 3 * (d + 1); i++) begin
      #3;
      if (pbus.tick) begin
        if (last < 0) check_eq("presc_first", 32'(i), 32'(d));
        else check_eq("presc_period", 32'(i - last), 32'(d + 1));
        last = i;
        ticks++;
      end
      @(posedge clk); #1;
    end
    check_eq("presc_ticks", 32'(ticks), 32'd3);
    $display("prescaler div_sel=%0d: %0d ticks observed", d, ticks);
  endtask

  int seq_a[5] = '{4, 3, 2, 1, 0};
  int seq_b[9] = '{2, 2, 2, 2, 1, 1, 1, 1, 0};
  int seq_c[7] = '{3, 2, 1, 3, 2, 1, 3};

  initial begin
    pbus.run = 1'b0;
    pbus.clear = 1'b0;
    pbus.div_sel = 4'd0;
    model_reset();

    // Reset held for two cycles.
    rst_n = 1'b0;
    cycle();
    cycle();
    check_eq("reset_uo", 32'(uo_out), 32'h00);
    check_eq("reset_uio", 32'(uio_out), 32'h00);
    rst_n = 1'b1;
    cycle();
    $display("reset: uo_out=%02h uio_out=%02h uio_oe=%02h", uo_out, uio_out, uio_oe);

    // load=5, div_sel=0.
    uio_in = 8'd5;
    ui_in = 8'h01;
    cycle();
    check_eq("a_count_load", 32'(uo_out[5:0]), 32'd5);
    check_eq("a_busy", 32'(uio_out[6]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("a_count", 32'(uo_out[5:0]), 32'(seq_a[i]));
    end
    check_eq("a_zero", 32'(uo_out[7]), 32'd1);
    check_eq("a_done", 32'(uio_out[7]), 32'd1);
    check_eq("a_busy_drop", 32'(uio_out[6]), 32'd0);
    $display("scenario load=5 div=0 finished");
    go_idle();

    // load=2, div_sel=3: four cycles per count value.
    uio_in = 8'd2;
    ui_in = 8'h30;
    cycle();
    ui_in = 8'h31;
    for (int i = 0; i < 9; i++) begin
      cycle();
      check_eq("b_count", 32'(uo_out[5:0]), 32'(seq_b[i]));
      check_eq("b_tick", 32'(uo_out[6]), 32'((i == 4) || (i == 8)));
    end
    $display("scenario load=2 div=3 finished");
    go_idle();

    // load=3 with auto-reload.
    uio_in = 8'd3;
    ui_in = 8'h04;
    cycle();
    ui_in = 8'h05;
    for (int i = 0; i < 7; i++) begin
      cycle();
      check_eq("c_count", 32'(uo_out[5:0]), 32'(seq_c[i]));
      check_eq("c_zero", 32'(uo_out[7]), 32'((i == 3) || (i == 6)));
      check_eq("c_done", 32'(uio_out[7]), 32'd0);
    end
    $display("scenario reload load=3 finished");
    go_idle();

    // load=10, pause at 7 for five cycles, resume, then abort.
    uio_in = 8'd10;
    ui_in = 8'h01;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("d_count7", 32'(uo_out[5:0]), 32'd7);
    ui_in = 8'h03;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("d_paused", 32'(uo_out[5:0]), 32'd7);
    end
    ui_in = 8'h01;
    for (int i = 0; i < 3; i++) cycle();
    ui_in = 8'h09;
    cycle();
    check_eq("d_abort_count", 32'(uo_out[5:0]), 32'd0);
    check_eq("d_abort_uio", 32'(uio_out), 32'd0);
    $display("scenario pause/abort finished");
    go_idle();

    // load=0: immediate DONE; held start does not restart.
    uio_in = 8'd0;
    ui_in = 8'h01;
    cycle();
    check_eq("e_zero", 32'(uo_out), 32'h80);
    check_eq("e_done", 32'(uio_out), 32'h80);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("e_hold", 32'(uo_out), 32'h00);
    end
    $display("scenario load=0 finished");
    go_idle();

    // Randomized traffic, with a mid-run reset while start is held.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] u;
      u = ui_in;
      if ($urandom_range(0, 7) == 0) u[0] = ~u[0];
      if ($urandom_range(0, 15) == 0) u[1] = ~u[1];
      if ($urandom_range(0, 31) == 0) u[2] = ~u[2];
      u[3] = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 31) == 0)
        u[7:4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      ui_in = u;
      if ($urandom_range(0, 15) == 0)
        uio_in = {2'($urandom), ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 8))};
      if (n == 1500) begin
        ui_in[0] = 1'b1;
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end
    $display("random phase: %0d checks so far", n_checks);

    // Standalone prescaler periods and a live drop of div_sel.
    ui_in = 8'h00;
    presc_period(0);
    presc_period(3);
    presc_period(9);
    pbus.div_sel = 4'd10;
    pbus.clear = 1'b1;
    pbus.run = 1'b0;
    @(posedge clk); #1;
    pbus.clear = 1'b0;
    pbus.run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #3;
      check_eq("presc_high_div", 32'(pbus.tick), 32'd0);
      @(posedge clk); #1;
    end
    pbus.div_sel = 4'd2;
    #3;
    check_eq("presc_lowered", 32'(pbus.tick), 32'd1);
    @(posedge clk); #4;
    check_eq("presc_after_lower", 32'(pbus.tick), 32'd0);
    pbus.run = 1'b0;
    $display("prescaler live div_sel drop finished");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
